multi_sample_hold: RTL and testbench
====================================

MULTI_SAMPLE_HOLD -- requirements
Module: multi_sample_hold

Interface
REQ-001 Parameter WIDTH, default 16, sample width in bits per channel.
REQ-002 Parameter CHANNELS, default 2, number of independent channels (range 1..8).
REQ-003 Parameter DECIM_W, default 8, width of the decimation ratio input.
REQ-004 Parameter TIMEOUT_W, default 16, width of the staleness timeout counter and input.
REQ-005 One clock; reset is synchronous and active-high; ports clk_i and rst_i.
REQ-006 clk_i  in  1  system clock; all logic on rising edge.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 data_valid_i  in  CHANNELS  per-channel input strobe; bit c qualifies channel c.
REQ-009 data_i  in  CHANNELS*WIDTH  packed samples; channel c at bits [c*WIDTH +: WIDTH].
REQ-010 hold_i  in  1  global freeze; while high, no channel captures.
REQ-011 decim_i  in  DECIM_W  decimation ratio N; 0 and 1 both mean capture every valid.
REQ-012 timeout_i  in  TIMEOUT_W  staleness threshold in clk_i cycles; 0 disables staleness.
REQ-013 data_valid_o  out  CHANNELS  one-cycle pulse per channel on capture.
REQ-014 data_o  out  CHANNELS*WIDTH  last captured sample per channel, same packing as data_i.
REQ-015 stale_o  out  CHANNELS  channel has not captured for at least timeout_i cycles.

Function
REQ-016 Each channel shall keep a decimation counter cnt (DECIM_W bits) counting accepted strobes.
REQ-017 Accepted strobe: data_valid_i[c]=1 and hold_i=0; strobes while hold_i=1 are discarded and leave cnt unchanged.
REQ-018 On an accepted strobe with cnt=0, channel shall capture data_i slice into data_o and pulse data_valid_o[c] on the next cycle (latency 1).
REQ-019 On every accepted strobe cnt shall advance: cnt := 0 if cnt >= decim_i-1 (or decim_i<=1), else cnt+1.
REQ-020 decim_i change mid-count: wrap rule of REQ-019 (>= compare) shall apply with the new value; no sample lost beyond one partial period.
REQ-021 data_o shall hold its value indefinitely between captures; data_valid_o shall be 0 in every cycle without a capture.
REQ-022 Back-to-back strobes with N<=1 shall produce back-to-back captures and continuous data_valid_o=1.
REQ-023 Channels shall be fully independent; simultaneous strobes on all channels shall all capture in the same cycle.
REQ-024 Staleness counter age (TIMEOUT_W bits) per channel: cleared to 0 on capture, else increments, saturating at all-ones.
REQ-025 stale_o[c] = (timeout_i != 0) and (age >= timeout_i), registered; capture clears stale_o[c] on the following cycle.

Reset
REQ-026 With rst_i=1 at a clock edge: data_o=0, data_valid_o=0, cnt=0, age=0, stale_o=0 on the next cycle.
REQ-027 Reset shall take priority over a simultaneous strobe; that strobe is discarded.
REQ-028 After reset deasserts, the first accepted strobe per channel shall capture (cnt=0).

Configuration
REQ-029 Macro MULTI_SAMPLE_HOLD_STALE_EN defined: age counters, timeout_i and stale_o implemented per REQ-024/025.
REQ-030 Macro undefined: no age counters; timeout_i ignored; stale_o tied to 0; ports retained.

Structure
REQ-031 Package sample_hold_pkg shall hold default parameter constants (WIDTH, DECIM_W, TIMEOUT_W) and the MAX_CHANNELS=8 limit.
REQ-032 Per-channel logic shall be one sub-module sample_hold_channel, instantiated CHANNELS times via generate.

Verification
REQ-033 Reset then decim_i=0, ch0 strobe data 0x1234 -> next cycle data_o[15:0]=0x1234, data_valid_o[0]=1 for one cycle.
REQ-034 decim_i=3, ch1 strobes with 1,2,3,4,5,6,7 -> captures 1,4,7; data_o ch1 holds 1 then 4 then 7.
REQ-035 hold_i=1 during strobe 0xAAAA after capture 0x5555 -> no pulse, data_o stays 0x5555, cnt unchanged.
REQ-036 STALE_EN, timeout_i=10, no strobes after capture -> stale_o=1 from cycle 10 after capture; strobe -> stale_o=0 one cycle later; timeout_i=0 -> stale_o=0 always.
REQ-037 rst_i=1 coincident with strobe 0xBEEF -> data_o=0, data_valid_o=0; next strobe 0x0001 captured regardless of prior cnt.
REQ-038 All channels strobe same cycle with distinct data, decim_i=1 -> all data_valid_o bits high together, each data_o slice correct.

Source files
------------

// File: rtl/sample_hold_pkg.sv
// Shared defaults and limits for the multi-channel sample-and-hold block.
package sample_hold_pkg;
  localparam int WIDTH_DEF     = 16;
  localparam int CHANNELS_DEF  = 2;
  localparam int DECIM_W_DEF   = 8;
  localparam int TIMEOUT_W_DEF = 16;
  localparam int MAX_CHANNELS  = 8;
endpackage

// File: rtl/sample_hold_channel.sv
// One channel: decimating capture register with optional staleness tracking
// (staleness built only when MULTI_SAMPLE_HOLD_STALE_EN is defined).
module sample_hold_channel
  import sample_hold_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DECIM_W   = DECIM_W_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 hold_i,
  input  logic [DECIM_W-1:0]   decim_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic                 valid_o,
  output logic [WIDTH-1:0]     data_o,
  output logic                 stale_o
);

  logic [DECIM_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               vld_q, vld_d;
  logic               accept, capture, wrap;

  // Wrap test uses >= so a ratio lowered mid-count still wraps promptly.
  always_comb begin
    accept  = valid_i & ~hold_i;
    capture = accept && (cnt_q == '0);
    wrap    = (decim_i <= DECIM_W'(1)) || (cnt_q >= (decim_i - DECIM_W'(1)));
    cnt_d   = cnt_q;
    if (accept) cnt_d = wrap ? '0 : (cnt_q + DECIM_W'(1));
    data_d  = capture ? data_i : data_q;
    vld_d   = capture;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign valid_o = vld_q;
  assign data_o  = data_q;

`ifdef MULTI_SAMPLE_HOLD_STALE_EN
  logic [TIMEOUT_W-1:0] age_q, age_d;
  logic                 stale_q, stale_d;

  // Flag tracks the age being written this cycle, so it rises with age==timeout.
  always_comb begin
    age_d   = capture ? '0 : ((&age_q) ? age_q : (age_q + TIMEOUT_W'(1)));
    stale_d = (timeout_i != '0) && (age_d >= timeout_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      age_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      age_q   <= age_d;
      stale_q <= stale_d;
    end
  end

  assign stale_o = stale_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_i;
  assign stale_o        = 1'b0;
`endif

endmodule

// File: rtl/multi_sample_hold.sv
// Multi-channel decimating sample-and-hold; one sample_hold_channel per channel.
// Staleness detection is enabled with MULTI_SAMPLE_HOLD_STALE_EN.
module multi_sample_hold
  import sample_hold_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int CHANNELS  = CHANNELS_DEF,
  parameter int DECIM_W   = DECIM_W_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CHANNELS-1:0]       data_valid_i,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  input  logic                      hold_i,
  input  logic [DECIM_W-1:0]        decim_i,
  input  logic [TIMEOUT_W-1:0]      timeout_i,
  output logic [CHANNELS-1:0]       data_valid_o,
  output logic [CHANNELS*WIDTH-1:0] data_o,
  output logic [CHANNELS-1:0]       stale_o
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    sample_hold_channel #(
      .WIDTH    (WIDTH),
      .DECIM_W  (DECIM_W),
      .TIMEOUT_W(TIMEOUT_W)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .valid_i  (data_valid_i[c]),
      .data_i   (data_i[c*WIDTH +: WIDTH]),
      .hold_i   (hold_i),
      .decim_i  (decim_i),
      .timeout_i(timeout_i),
      .valid_o  (data_valid_o[c]),
      .data_o   (data_o[c*WIDTH +: WIDTH]),
      .stale_o  (stale_o[c])
    );
  end

endmodule

// File: tb/tb_multi_sample_hold.sv
// Bench for multi_sample_hold: vector table through a scoreboard queue, then
// hand-written staleness sequence (checks differ with MULTI_SAMPLE_HOLD_STALE_EN).
module tb_multi_sample_hold;
  localparam int W  = 16;
  localparam int CH = 3;
  localparam int DW = 8;
  localparam int TW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   vld_in;
  logic [CH*W-1:0] din;
  logic            hold;
  logic [DW-1:0]   decim;
  logic [TW-1:0]   tmo;
  logic [CH-1:0]   vld_out;
  logic [CH*W-1:0] dout;
  logic [CH-1:0]   stale;

  int total = 0;
  int bad   = 0;

  multi_sample_hold #(.WIDTH(W), .CHANNELS(CH), .DECIM_W(DW), .TIMEOUT_W(TW)) dut (
    .clk_i(clk), .rst_i(rst), .data_valid_i(vld_in), .data_i(din), .hold_i(hold),
    .decim_i(decim), .timeout_i(tmo), .data_valid_o(vld_out), .data_o(dout),
    .stale_o(stale)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          hold;
    logic [DW-1:0] decim;
    logic [CH-1:0] vld;
    logic [W-1:0]  d0, d1, d2;
    logic [CH-1:0] ev;
    logic [W-1:0]  e0, e1, e2;
  } vec_t;

  typedef struct {
    logic [CH-1:0]   ev;
    logic [CH*W-1:0] ed;
    int              idx;
  } exp_t;

  vec_t vt[20];
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic h, input logic [DW-1:0] n,
                              input logic [CH-1:0] v, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] c,
                              input logic [CH-1:0] ev, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic [W-1:0] z);
    vec_t t;
    t.rst = r; t.hold = h; t.decim = n; t.vld = v; t.d0 = a; t.d1 = b; t.d2 = c;
    t.ev = ev; t.e0 = x; t.e1 = y; t.e2 = z;
    return t;
  endfunction

  // Drive on the cycle after an edge, sample 1 time unit after the next edge.
  task automatic step(input logic r, input logic h, input logic [DW-1:0] n,
                      input logic [CH-1:0] v, input logic [CH*W-1:0] d);
    rst = r; hold = h; decim = n; vld_in = v; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; hold = 1'b0; decim = '0; vld_in = '0; din = '0; tmo = '0;

    //         rst  hold dec vld     d0       d1       d2       ev      e0       e1       e2
    vt[0]  = mk(1'b1,1'b0,8'd0,3'b000,16'h0000,16'h0000,16'h0000,3'b000,16'h0000,16'h0000,16'h0000);
    vt[1]  = mk(1'b0,1'b0,8'd0,3'b001,16'h1234,16'h0000,16'h0000,3'b001,16'h1234,16'h0000,16'h0000);
    vt[2]  = mk(1'b0,1'b0,8'd0,3'b000,16'hFFFF,16'h0000,16'h0000,3'b000,16'h1234,16'h0000,16'h0000);
    vt[3]  = mk(1'b0,1'b0,8'd3,3'b010,16'h0000,16'h0001,16'h0000,3'b010,16'h1234,16'h0001,16'h0000);
    vt[4]  = mk(1'b0,1'b0,8'd3,3'b010,16'h0000,16'h0002,16'h0000,3'b000,16'h1234,16'h0001,16'h0000);
    vt[5]  = mk(1'b0,1'b0,8'd3,3'b010,16'h0000,16'h0003,16'h0000,3'b000,16'h1234,16'h0001,16'h0000);
    vt[6]  = mk(1'b0,1'b0,8'd3,3'b010,16'h0000,16'h0004,16'h0000,3'b010,16'h1234,16'h0004,16'h0000);
    vt[7]  = mk(1'b0,1'b0,8'd3,3'b010,16'h0000,16'h0005,16'h0000,3'b000,16'h1234,16'h0004,16'h0000);
    vt[8]  = mk(1'b0,1'b0,8'd3,3'b010,16'h0000,16'h0006,16'h0000,3'b000,16'h1234,16'h0004,16'h0000);
    vt[9]  = mk(1'b0,1'b0,8'd3,3'b010,16'h0000,16'h0007,16'h0000,3'b010,16'h1234,16'h0007,16'h0000);
    // decim=2 on ch0: capture, held strobe must not advance cnt, skip, capture
    vt[10] = mk(1'b0,1'b0,8'd2,3'b001,16'h5555,16'h0000,16'h0000,3'b001,16'h5555,16'h0007,16'h0000);
    vt[11] = mk(1'b0,1'b1,8'd2,3'b001,16'hAAAA,16'h0000,16'h0000,3'b000,16'h5555,16'h0007,16'h0000);
    vt[12] = mk(1'b0,1'b0,8'd2,3'b001,16'h0BBB,16'h0000,16'h0000,3'b000,16'h5555,16'h0007,16'h0000);
    vt[13] = mk(1'b0,1'b0,8'd2,3'b001,16'h0CCC,16'h0000,16'h0000,3'b001,16'h0CCC,16'h0007,16'h0000);
    // ratio drops to 1 with ch0/ch1 mid-count: they finish the partial period first
    vt[14] = mk(1'b0,1'b0,8'd1,3'b111,16'h0011,16'h0022,16'h0033,3'b100,16'h0CCC,16'h0007,16'h0033);
    vt[15] = mk(1'b0,1'b0,8'd1,3'b111,16'h0044,16'h0055,16'h0066,3'b111,16'h0044,16'h0055,16'h0066);
    vt[16] = mk(1'b0,1'b0,8'd1,3'b111,16'h0077,16'h0088,16'h0099,3'b111,16'h0077,16'h0088,16'h0099);
    vt[17] = mk(1'b0,1'b0,8'd3,3'b001,16'h0101,16'h0000,16'h0000,3'b001,16'h0101,16'h0088,16'h0099);
    vt[18] = mk(1'b1,1'b0,8'd3,3'b001,16'hBEEF,16'h0000,16'h0000,3'b000,16'h0000,16'h0000,16'h0000);
    vt[19] = mk(1'b0,1'b0,8'd3,3'b001,16'h0001,16'h0000,16'h0000,3'b001,16'h0001,16'h0000,16'h0000);

    for (int i = 0; i < 20; i++) begin
      e.ev  = vt[i].ev;
      e.ed  = {vt[i].e2, vt[i].e1, vt[i].e0};
      e.idx = i;
      sb.push_back(e);
      step(vt[i].rst, vt[i].hold, vt[i].decim, vt[i].vld, {vt[i].d2, vt[i].d1, vt[i].d0});
      if (sb.size() == 0) begin
        chk("sb_empty", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_valid", e.idx), 64'(vld_out), 64'(e.ev));
        chk($sformatf("vec%0d_data", e.idx), 64'(dout), 64'(e.ed));
        chk($sformatf("vec%0d_stale_off", e.idx), 64'(stale), 64'd0);
      end
    end

    // Staleness: capture on ch0, then idle with timeout 10
    step(1'b1, 1'b0, 8'd0, 3'b000, '0);
    tmo = 16'd10;
    step(1'b0, 1'b0, 8'd0, 3'b001, 48'h0042);
    chk("stale_cap_valid", 64'(vld_out), 64'd1);
    chk("stale_cap_flag", 64'(stale[0]), 64'd0);
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, 8'd0, 3'b000, '0);
`ifdef MULTI_SAMPLE_HOLD_STALE_EN
      chk($sformatf("stale_age%0d", k), 64'(stale[0]), (k >= 10) ? 64'd1 : 64'd0);
`else
      chk($sformatf("stale_age%0d", k), 64'(stale[0]), 64'd0);
`endif
    end
    step(1'b0, 1'b0, 8'd0, 3'b001, 48'h0043);
    chk("stale_clear_valid", 64'(vld_out), 64'd1);
    chk("stale_clear_flag", 64'(stale[0]), 64'd0);
`ifdef MULTI_SAMPLE_HOLD_STALE_EN
    chk("stale_ch1_aged", 64'(stale[1]), 64'd1);
`else
    chk("stale_ch1_aged", 64'(stale[1]), 64'd0);
`endif
    tmo = 16'd0;
    step(1'b0, 1'b0, 8'd0, 3'b000, '0);
    chk("stale_tmo0", 64'(stale), 64'd0);
    chk("hold_data", 64'(dout), 64'h0043);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
